// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide result back end: op codes,
// FSM states and op-classification helpers.
package md_pkg;

   localparam logic [3:0] OP_DIV    = 4'b0000;
   localparam logic [3:0] OP_DIVU   = 4'b0001;
   localparam logic [3:0] OP_REM    = 4'b0010;
   localparam logic [3:0] OP_REMU   = 4'b0011;
   localparam logic [3:0] OP_MUL    = 4'b0100;
   localparam logic [3:0] OP_MULH   = 4'b0101;
   localparam logic [3:0] OP_MULHSU = 4'b0110;
   localparam logic [3:0] OP_MULHU  = 4'b0111;
   localparam logic [3:0] OP_DIVW   = 4'b1000;
   localparam logic [3:0] OP_DIVUW  = 4'b1001;
   localparam logic [3:0] OP_REMW   = 4'b1010;
   localparam logic [3:0] OP_REMUW  = 4'b1011;
   localparam logic [3:0] OP_MULW   = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FIX,
      ST_OUT
   } md_state_t;

   function automatic logic is_w(input logic [3:0] op);
      return op[3];
   endfunction

   // Every non-W code is legal; W forms stop at MULW.
   function automatic logic is_legal(input logic [3:0] op);
      return !op[3] || (op[2:0] <= 3'b100);
   endfunction

endpackage

// File: rtl/md_cneg.sv
// Conditional two's-complement negator. With split set, the two halves are
// negated independently (no carry crosses the midpoint).
module md_cneg #(
   parameter int W = 128
) (
   input  logic [W-1:0] din,
   input  logic         neg,
   input  logic         split,
   output logic [W-1:0] dout
);
   localparam int H = W / 2;

   logic [W-1:0] inv;
   logic [H:0]   lo_sum;
   logic         hi_cin;

   assign inv    = din ^ {W{neg}};
   assign lo_sum = {1'b0, inv[H-1:0]} + {{H{1'b0}}, neg};
   // Split mode injects its own +1 into the high half instead of the ripple carry.
   assign hi_cin = split ? neg : lo_sum[H];
   assign dout   = {inv[W-1:H] + {{(W-H-1){1'b0}}, hi_cin}, lo_sum[H-1:0]};

endmodule

// File: rtl/md_out.sv
// Multiply/divide result conditioning: waits for the unsigned core result,
// restores sign, selects the half and sign-extends W forms.
module md_out
   import md_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   input  logic [3:0]      md_op_i,
   input  logic            x_sign_i,
   input  logic            y_sign_i,
   input  logic            exc_i,
   input  logic [XLEN-1:0] exc_result_i,
   input  logic            kill_i,
   input  logic            core_valid_i,
   input  logic [XLEN-1:0] core_hi_i,
   input  logic [XLEN-1:0] core_lo_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   md_state_t         state_reg, state_next;
   logic [3:0]        op_reg, op_next;
   logic              xs_reg, xs_next;
   logic              ys_reg, ys_next;
   logic [2*XLEN-1:0] raw_reg, raw_next;
   logic [XLEN-1:0]   result_reg, result_next;

   logic              is_mul;
   logic              neg;
   logic [2*XLEN-1:0] fixed;
   logic [XLEN-1:0]   sel;
   logic [XLEN-1:0]   fix_value;

   // For legal codes bit 2 is set only on multiplies.
   assign is_mul = op_reg[2];

   always_comb begin
      neg = 1'b0;
      if (is_mul) begin
         case (op_reg[1:0])
            2'b00, 2'b01: neg = xs_reg ^ ys_reg;
            2'b10:        neg = xs_reg;
            default:      neg = 1'b0;
         endcase
      end else if (!op_reg[0]) begin
         neg = op_reg[1] ? xs_reg : (xs_reg ^ ys_reg);
      end
   end

   md_cneg #(.W(2 * XLEN)) u_cneg (
      .din   (raw_reg),
      .neg   (neg),
      .split (~is_mul),
      .dout  (fixed)
   );

   always_comb begin
      sel = fixed[XLEN-1:0];
      if (is_mul) begin
         if (op_reg[1:0] != 2'b00) sel = fixed[2*XLEN-1:XLEN];
      end else if (op_reg[1]) begin
         sel = fixed[2*XLEN-1:XLEN];
      end

      fix_value = sel;
      if (!is_legal(op_reg))
         fix_value = '0;
      else if (is_w(op_reg))
         fix_value = {{(XLEN-32){sel[31]}}, sel[31:0]};
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      xs_next     = xs_reg;
      ys_next     = ys_reg;
      raw_next    = raw_reg;
      result_next = result_reg;
      if (kill_i) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (issue_valid_i) begin
                  op_next = md_op_i;
                  xs_next = x_sign_i;
                  ys_next = y_sign_i;
                  if (exc_i) begin
                     result_next = exc_result_i;
                     state_next  = ST_OUT;
                  end else begin
                     state_next = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (core_valid_i) begin
                  raw_next   = {core_hi_i, core_lo_i};
                  state_next = ST_FIX;
               end
            end
            ST_FIX: begin
               result_next = fix_value;
               state_next  = ST_OUT;
            end
            ST_OUT: begin
               if (result_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg  <= ST_IDLE;
         op_reg     <= '0;
         xs_reg     <= 1'b0;
         ys_reg     <= 1'b0;
         raw_reg    <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         xs_reg     <= xs_next;
         ys_reg     <= ys_next;
         raw_reg    <= raw_next;
         result_reg <= result_next;
      end
   end

   assign issue_ready_o  = (state_reg == ST_IDLE);
   assign result_valid_o = (state_reg == ST_OUT);
   assign busy_o         = (state_reg != ST_IDLE);
   assign result_o       = result_reg;

endmodule
